// File: rtl/flit_output_arbiter.sv
// flit_output_arbiter
//   Round-robin, wormhole-locked output arbiter for one router output port.
//   It pops whole packets from one input FIFO at a time and forwards each
//   flit through a single register stage to the output-port FIFO. Pops are
//   throttled on the downstream almost_full flag.
//   Flit format: bit 0 = head flag, bit 1 = tail flag.
//
// Ports:
//   clk             single clock, rising edge
//   rst             synchronous active-high reset
//   in_empty        empty flag of input FIFO i on bit i
//   in_data         head-of-queue flit of input FIFO i on [i*DATA_W +: DATA_W]
//   in_rd_en        combinational one-hot (or zero) pop strobe to input FIFOs
//   out_almost_full almost_full of the downstream FIFO
//   out_wr_en       registered write strobe to the downstream FIFO
//   out_data        registered flit to the downstream FIFO
//   grant           registered one-hot owner while a packet is open, 0 in IDLE
//   err             sticky protocol-error flag
//
// Configuration macro:
//   FLIT_ARB_ERR_DROP_EN  when defined, a headless front flit reached first in
//                         IDLE scan order is popped and discarded and err is
//                         set; when undefined such inputs are ineligible and
//                         err stays 0.
module flit_output_arbiter #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          in_empty,
  input  logic [N_IN*DATA_W-1:0]   in_data,
  output logic [N_IN-1:0]          in_rd_en,
  input  logic                     out_almost_full,
  output logic                     out_wr_en,
  output logic [DATA_W-1:0]        out_data,
  output logic [N_IN-1:0]          grant,
  output logic                     err
);

  localparam int PTR_W = $clog2(N_IN);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [PTR_W-1:0]    owner_r, owner_nxt_s;
  logic [PTR_W-1:0]    rr_ptr_r, rr_ptr_nxt_s;
  logic [N_IN-1:0]     grant_r, grant_nxt_s;
  logic                wr_r, wr_nxt_s;
  logic [DATA_W-1:0]   data_r, data_nxt_s;
  logic                err_r, err_nxt_s;

  logic [DATA_W-1:0]   flit_s [N_IN];
  logic                found_s;
  logic [PTR_W-1:0]    pick_s;
  logic [PTR_W:0]      scan_sum_s;
  logic [PTR_W-1:0]    scan_idx_s;
  logic                scan_cand_s;
  logic                pop_s;
  logic [PTR_W-1:0]    pop_idx_s;
  logic [DATA_W-1:0]   popped_s;

  // Next input index with wrap at N_IN (N_IN need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == PTR_W'(N_IN - 1)) begin
      r = '0;
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  function automatic logic [N_IN-1:0] one_hot(input logic [PTR_W-1:0] idx);
    logic [N_IN-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Split the flat input bus into per-input flits.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      flit_s[i] = in_data[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin scan starting at rr_ptr; first candidate wins.
  always_comb begin
    found_s     = 1'b0;
    pick_s      = '0;
    scan_sum_s  = '0;
    scan_idx_s  = '0;
    scan_cand_s = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      scan_sum_s = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
      scan_idx_s = (scan_sum_s >= (PTR_W+1)'(N_IN)) ?
                   PTR_W'(scan_sum_s - (PTR_W+1)'(N_IN)) : scan_sum_s[PTR_W-1:0];
`ifdef FLIT_ARB_ERR_DROP_EN
      // Any non-empty input is a candidate; a headless one is dropped later.
      scan_cand_s = !in_empty[scan_idx_s];
`else
      scan_cand_s = !in_empty[scan_idx_s] && flit_s[scan_idx_s][0];
`endif
      pick_s  = (scan_cand_s && !found_s) ? scan_idx_s : pick_s;
      found_s = found_s | scan_cand_s;
    end
  end

  // FSM next-state, pop decision and next register values.
  always_comb begin
    state_nxt_s  = state_r;
    owner_nxt_s  = owner_r;
    rr_ptr_nxt_s = rr_ptr_r;
    grant_nxt_s  = grant_r;
    wr_nxt_s     = 1'b0;
    data_nxt_s   = data_r;
    err_nxt_s    = err_r;
    pop_s        = 1'b0;
    pop_idx_s    = '0;

    case (state_r)
      ST_IDLE: begin
        pop_s     = found_s;
        pop_idx_s = pick_s;
      end
      ST_LOCKED: begin
        pop_s     = !in_empty[owner_r];
        pop_idx_s = owner_r;
      end
      default: begin
        pop_s     = 1'b0;
        pop_idx_s = '0;
      end
    endcase

    // One slot of downstream headroom covers the registered in-flight flit.
    if (rst || out_almost_full) begin
      pop_s = 1'b0;
    end else begin
      pop_s = pop_s;
    end

    popped_s = flit_s[pop_idx_s];
    in_rd_en = pop_s ? one_hot(pop_idx_s) : '0;

    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          if (popped_s[0]) begin
            wr_nxt_s   = 1'b1;
            data_nxt_s = popped_s;
            if (popped_s[1]) begin
              rr_ptr_nxt_s = ptr_inc(pop_idx_s);
            end else begin
              state_nxt_s = ST_LOCKED;
              owner_nxt_s = pop_idx_s;
              grant_nxt_s = one_hot(pop_idx_s);
            end
          end else begin
            // Headless flit is discarded; rr_ptr is left alone.
            err_nxt_s = 1'b1;
          end
        end else begin
          wr_nxt_s = 1'b0;
        end
      end
      ST_LOCKED: begin
        if (pop_s) begin
          wr_nxt_s   = 1'b1;
          data_nxt_s = popped_s;
          if (popped_s[1]) begin
            state_nxt_s  = ST_IDLE;
            rr_ptr_nxt_s = ptr_inc(owner_r);
            grant_nxt_s  = '0;
          end else begin
            state_nxt_s = ST_LOCKED;
          end
        end else begin
          wr_nxt_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      owner_r  <= '0;
      rr_ptr_r <= '0;
      grant_r  <= '0;
      wr_r     <= 1'b0;
      data_r   <= '0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      owner_r  <= owner_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
      grant_r  <= grant_nxt_s;
      wr_r     <= wr_nxt_s;
      data_r   <= data_nxt_s;
      err_r    <= err_nxt_s;
    end
  end

  assign out_wr_en = wr_r;
  assign out_data  = data_r;
  assign grant     = grant_r;
  assign err       = err_r;

endmodule
